soric_sram_bank_arbiter: RTL and testbench

//  Shares NSRAM 1rw1r SRAM macros (port 0, read/write) among NCORE core data ports.
//  - Decodes each core's address to a bank.
//  - Arbitrates each bank round-robin and drives the macro's active-low controls.
//  - Returns a read-data/response pipeline per core, with req/gnt/rvalid semantics.

---
 rtl/soric_pkg.sv | 20 ++
 rtl/soric_rr_arbiter.sv | 43 ++++
 rtl/soric_sram_bank_arbiter.sv | 176 +++++++++++++++++
 tb/tb_soric_sram_bank_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soric_pkg.sv
// Shared types and helpers for the soric SRAM bank arbiter.
// Holds the bank-index width function, the response struct and the stall counter width.
package soric_pkg;

    localparam int STALL_CNT_W = 16;
    localparam int RESP_BANK_W = 8;

    // Response token carried down each core's pipe
    typedef struct packed {
        logic                   valid;
        logic                   oor;
        logic [RESP_BANK_W-1:0] bank;
    } resp_t;

    // Bank index width; a single bank still needs a one-bit index
    function automatic int bank_w(input int nsram);
        return (nsram > 1) ? $clog2(nsram) : 1;
    endfunction

endpackage

// File: rtl/soric_rr_arbiter.sv
// Round-robin arbiter for one SRAM bank: N requests in, one-hot grant out.
// Ports: clk_i, rst_ni, req_i[N], gnt_o[N] (combinational, pointer advances past winner).
module soric_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win;
    logic             found;

    // First requester at or after the pointer wins
    always_comb begin : p_pick
        int idx;
        idx   = 0;
        gnt_o = '0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                win        = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (int'(win) == N - 1) ? '0 : win + PTR_W'(1);
        end
    end

endmodule

// File: rtl/soric_sram_bank_arbiter.sv
// Shares NSRAM single-port SRAM banks among NCORE core data ports.
// Ports: m_* core req/gnt/rvalid buses, s_* active-low macro controls, stall_cnt_o.
module soric_sram_bank_arbiter
    import soric_pkg::*;
#(
    parameter int NCORE       = 2,
    parameter int NSRAM       = 4,
    parameter int D_ADDR_W    = 14,
    parameter int SRAM_ADDR_W = 11,
    parameter int READ_LAT    = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NCORE-1:0]                m_req_i,
    input  logic [NCORE*D_ADDR_W-1:0]       m_addr_i,
    input  logic [NCORE-1:0]                m_we_i,
    input  logic [NCORE*4-1:0]              m_be_i,
    input  logic [NCORE*32-1:0]             m_wdata_i,
    output logic [NCORE-1:0]                m_gnt_o,
    output logic [NCORE-1:0]                m_rvalid_o,
    output logic [NCORE*32-1:0]             m_rdata_o,
    output logic [NCORE-1:0]                m_err_o,
    output logic [NSRAM-1:0]                s_csb_o,
    output logic [NSRAM-1:0]                s_web_o,
    output logic [NSRAM*4-1:0]              s_wmask_o,
    output logic [NSRAM*(SRAM_ADDR_W-2)-1:0] s_addr_o,
    output logic [NSRAM*32-1:0]             s_din_o,
    input  logic [NSRAM*32-1:0]             s_dout_i,
    output logic [STALL_CNT_W-1:0]          stall_cnt_o
);

    localparam int BANK_W = bank_w(NSRAM);
    localparam int WORD_W = SRAM_ADDR_W - 2;
    localparam int TOP_LSB = SRAM_ADDR_W + BANK_W;
    localparam int HI_W = D_ADDR_W - TOP_LSB;

    logic [BANK_W-1:0] bank [NCORE];
    logic [WORD_W-1:0] word [NCORE];
    logic [NCORE-1:0]  oor;
    logic [NCORE-1:0]  bank_req [NSRAM];
    logic [NCORE-1:0]  bank_gnt [NSRAM];
    logic [NCORE-1:0]  gnt;
    logic [2*NCORE-1:0] unused_addr_lsb;

    always_comb begin
        unused_addr_lsb = '0;
        for (int c = 0; c < NCORE; c++) begin
            bank[c] = m_addr_i[c*D_ADDR_W+SRAM_ADDR_W +: BANK_W];
            word[c] = m_addr_i[c*D_ADDR_W+2 +: WORD_W];
            oor[c]  = |m_addr_i[c*D_ADDR_W+TOP_LSB +: HI_W];
            unused_addr_lsb[2*c +: 2] = m_addr_i[c*D_ADDR_W +: 2];
        end
    end

    // Reset gates every request so no bank fires while rst_ni is low
    always_comb begin
        for (int b = 0; b < NSRAM; b++) begin
            for (int c = 0; c < NCORE; c++) begin
                bank_req[b][c] = rst_ni & m_req_i[c] & ~oor[c]
                               & (bank[c] == BANK_W'(b));
            end
        end
    end

    for (genvar b = 0; b < NSRAM; b++) begin : g_bank
        soric_rr_arbiter #(
            .N (NCORE)
        ) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (bank_req[b]),
            .gnt_o  (bank_gnt[b])
        );
    end

    // OOR requests are accepted immediately and never reach a bank
    always_comb begin
        gnt = rst_ni ? (m_req_i & oor) : '0;
        for (int b = 0; b < NSRAM; b++) begin
            gnt = gnt | bank_gnt[b];
        end
        m_gnt_o = gnt;
    end

    always_comb begin
        s_csb_o   = '1;
        s_web_o   = '1;
        s_wmask_o = '0;
        s_addr_o  = '0;
        s_din_o   = '0;
        for (int b = 0; b < NSRAM; b++) begin
            for (int c = 0; c < NCORE; c++) begin
                if (bank_gnt[b][c]) begin
                    s_csb_o[b]               = 1'b0;
                    s_web_o[b]               = ~m_we_i[c];
                    s_wmask_o[b*4 +: 4]      = m_be_i[c*4 +: 4];
                    s_addr_o[b*WORD_W +: WORD_W] = word[c];
                    s_din_o[b*32 +: 32]      = m_wdata_i[c*32 +: 32];
                end
            end
        end
    end

    resp_t new_resp [NCORE];
    resp_t pipe_q   [NCORE][READ_LAT];
    logic  rd_q     [NCORE][READ_LAT];

    always_comb begin
        for (int c = 0; c < NCORE; c++) begin
            new_resp[c].valid = gnt[c];
            new_resp[c].oor   = oor[c];
            new_resp[c].bank  = RESP_BANK_W'(bank[c]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NCORE; c++) begin
                for (int k = 0; k < READ_LAT; k++) begin
                    pipe_q[c][k] <= '0;
                    rd_q[c][k]   <= 1'b0;
                end
            end
        end else begin
            for (int c = 0; c < NCORE; c++) begin
                pipe_q[c][0] <= new_resp[c];
                rd_q[c][0]   <= gnt[c] & ~m_we_i[c] & ~oor[c];
                for (int k = 1; k < READ_LAT; k++) begin
                    pipe_q[c][k] <= pipe_q[c][k-1];
                    rd_q[c][k]   <= rd_q[c][k-1];
                end
            end
        end
    end

    // Writes and OOR accesses return zero data
    always_comb begin
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        for (int c = 0; c < NCORE; c++) begin
            m_rvalid_o[c] = pipe_q[c][READ_LAT-1].valid;
            m_err_o[c]    = pipe_q[c][READ_LAT-1].valid
                          & pipe_q[c][READ_LAT-1].oor;
            for (int b = 0; b < NSRAM; b++) begin
                if (rd_q[c][READ_LAT-1]
                    && pipe_q[c][READ_LAT-1].bank == RESP_BANK_W'(b)) begin
                    m_rdata_o[c*32 +: 32] = s_dout_i[b*32 +: 32];
                end
            end
        end
    end

    logic [STALL_CNT_W-1:0] stall_q;
    logic [STALL_CNT_W:0]   stall_sum;

    always_comb begin
        stall_sum = {1'b0, stall_q};
        for (int c = 0; c < NCORE; c++) begin
            stall_sum = stall_sum
                      + (STALL_CNT_W+1)'(m_req_i[c] & ~gnt[c]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_sum[STALL_CNT_W] ? '1
                                              : stall_sum[STALL_CNT_W-1:0];
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_soric_sram_bank_arbiter.sv
// Bench for soric_sram_bank_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level model of the bank arbiter.
module tb_soric_sram_bank_arbiter;

    localparam int NCORE = 2;
    localparam int NSRAM = 4;
    localparam int DAW   = 14;
    localparam int SAW   = 11;
    localparam int RL    = 1;
    localparam int WW    = SAW - 2;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [NCORE-1:0]       m_req_i = '0;
    logic [NCORE*DAW-1:0]   m_addr_i = '0;
    logic [NCORE-1:0]       m_we_i = '0;
    logic [NCORE*4-1:0]     m_be_i = '0;
    logic [NCORE*32-1:0]    m_wdata_i = '0;
    logic [NCORE-1:0]       m_gnt_o;
    logic [NCORE-1:0]       m_rvalid_o;
    logic [NCORE*32-1:0]    m_rdata_o;
    logic [NCORE-1:0]       m_err_o;
    logic [NSRAM-1:0]       s_csb_o;
    logic [NSRAM-1:0]       s_web_o;
    logic [NSRAM*4-1:0]     s_wmask_o;
    logic [NSRAM*WW-1:0]    s_addr_o;
    logic [NSRAM*32-1:0]    s_din_o;
    logic [NSRAM*32-1:0]    s_dout_i;
    logic [15:0]            stall_cnt_o;

    soric_sram_bank_arbiter #(
        .NCORE       (NCORE),
        .NSRAM       (NSRAM),
        .D_ADDR_W    (DAW),
        .SRAM_ADDR_W (SAW),
        .READ_LAT    (RL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .m_req_i     (m_req_i),
        .m_addr_i    (m_addr_i),
        .m_we_i      (m_we_i),
        .m_be_i      (m_be_i),
        .m_wdata_i   (m_wdata_i),
        .m_gnt_o     (m_gnt_o),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .s_csb_o     (s_csb_o),
        .s_web_o     (s_web_o),
        .s_wmask_o   (s_wmask_o),
        .s_addr_o    (s_addr_o),
        .s_din_o     (s_din_o),
        .s_dout_i    (s_dout_i),
        .stall_cnt_o (stall_cnt_o)
    );

    // SRAM macros, one-cycle read latency
    logic [31:0] smem [NSRAM][512];
    logic [31:0] sdout [NSRAM];

    always @(posedge clk) begin : sram_model
        int wa;
        for (int b = 0; b < NSRAM; b++) begin
            wa = int'(s_addr_o[b*WW +: WW]);
            if (!s_csb_o[b]) begin
                if (!s_web_o[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (s_wmask_o[b*4+k])
                            smem[b][wa][8*k +: 8] <= s_din_o[b*32+8*k +: 8];
                end else begin
                    sdout[b] <= smem[b][wa];
                end
            end
        end
    end

    always_comb
        for (int b = 0; b < NSRAM; b++) s_dout_i[b*32 +: 32] = sdout[b];

    // Transaction-level model
    typedef struct {
        int          core;
        int          due;
        bit          oor;
        logic [31:0] data;
    } exp_t;

    exp_t        eq[$];
    int          rr_m [NSRAM];
    logic [31:0] shadow [NSRAM][512];
    int          stall_m;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic [NCORE-1:0] egnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        eq.delete();
        for (int b = 0; b < NSRAM; b++) rr_m[b] = 0;
        stall_m = 0;
        egnt = '0;
    endtask

    task automatic drive(input int c, input bit rq, input bit we,
                         input int a, input logic [3:0] be,
                         input logic [31:0] wd);
        m_req_i[c]            = rq;
        m_we_i[c]             = we;
        m_addr_i[c*DAW +: DAW] = DAW'(a);
        m_be_i[c*4 +: 4]      = be;
        m_wdata_i[c*32 +: 32] = wd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        int   a, win [NSRAM], bk [NCORE], wd [NCORE];
        bit   oo [NCORE];
        logic [NCORE-1:0] g, ev, ee;
        logic [31:0] ed [NCORE];
        exp_t keep[$];
        exp_t ne;
        @(negedge clk);
        if (!rst_ni) begin
            chk("rst_gnt", 32'(m_gnt_o), 0);
            chk("rst_csb", 32'(s_csb_o), 32'hF);
            chk("rst_web", 32'(s_web_o), 32'hF);
            chk("rst_rvalid", 32'(m_rvalid_o), 0);
            chk("rst_err", 32'(m_err_o), 0);
            chk("rst_stall", 32'(stall_cnt_o), 0);
            egnt = '0;
        end else begin
            for (int c = 0; c < NCORE; c++) begin
                a     = int'(m_addr_i[c*DAW +: DAW]);
                oo[c] = a >= 'h2000;
                bk[c] = (a >> 11) % NSRAM;
                wd[c] = (a >> 2) % 512;
            end
            g = '0;
            for (int c = 0; c < NCORE; c++)
                if (m_req_i[c] && oo[c]) g[c] = 1'b1;
            for (int b = 0; b < NSRAM; b++) begin
                win[b] = -1;
                for (int k = 0; k < NCORE; k++) begin
                    int c;
                    c = (rr_m[b] + k) % NCORE;
                    if (win[b] < 0 && m_req_i[c] && !oo[c] && bk[c] == b)
                        win[b] = c;
                end
                if (win[b] >= 0) g[win[b]] = 1'b1;
            end
            chk("gnt", 32'(m_gnt_o), 32'(g));
            for (int b = 0; b < NSRAM; b++) begin
                if (win[b] >= 0) begin
                    chk("csb", 32'(s_csb_o[b]), 0);
                    chk("web", 32'(s_web_o[b]), 32'(!m_we_i[win[b]]));
                    chk("wmask", 32'(s_wmask_o[b*4 +: 4]),
                        32'(m_be_i[win[b]*4 +: 4]));
                    chk("addr", 32'(s_addr_o[b*WW +: WW]), 32'(wd[win[b]]));
                    chk("din", s_din_o[b*32 +: 32], m_wdata_i[win[b]*32 +: 32]);
                end else begin
                    chk("csb", 32'(s_csb_o[b]), 1);
                    chk("web", 32'(s_web_o[b]), 1);
                    chk("wmask", 32'(s_wmask_o[b*4 +: 4]), 0);
                    chk("addr", 32'(s_addr_o[b*WW +: WW]), 0);
                    chk("din", s_din_o[b*32 +: 32], 0);
                end
            end
            ev = '0;
            ee = '0;
            for (int c = 0; c < NCORE; c++) ed[c] = '0;
            foreach (eq[i]) begin
                if (eq[i].due == cyc) begin
                    ev[eq[i].core] = 1'b1;
                    ee[eq[i].core] = eq[i].oor;
                    ed[eq[i].core] = eq[i].data;
                end else begin
                    keep.push_back(eq[i]);
                end
            end
            eq = keep;
            chk("rvalid", 32'(m_rvalid_o), 32'(ev));
            chk("err", 32'(m_err_o), 32'(ee));
            for (int c = 0; c < NCORE; c++)
                chk("rdata", m_rdata_o[c*32 +: 32], ed[c]);
            chk("stall", 32'(stall_cnt_o), 32'(stall_m));
            for (int c = 0; c < NCORE; c++)
                if (m_req_i[c] && !g[c] && stall_m < 'hFFFF) stall_m++;
            for (int c = 0; c < NCORE; c++) begin
                if (g[c]) begin
                    ne.core = c;
                    ne.due  = cyc + RL;
                    ne.oor  = oo[c];
                    ne.data = (!m_we_i[c] && !oo[c]) ? shadow[bk[c]][wd[c]] : 0;
                    eq.push_back(ne);
                    if (m_we_i[c] && !oo[c])
                        for (int k = 0; k < 4; k++)
                            if (m_be_i[c*4+k])
                                shadow[bk[c]][wd[c]][8*k +: 8] =
                                    m_wdata_i[c*32+8*k +: 8];
                end
            end
            for (int b = 0; b < NSRAM; b++)
                if (win[b] >= 0) rr_m[b] = (win[b] + 1) % NCORE;
            egnt = g;
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < NSRAM; b++) begin
            sdout[b] = '0;
            for (int w = 0; w < 512; w++) begin
                smem[b][w]   = '0;
                shadow[b][w] = '0;
            end
        end
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        model_reset();

        drive(0, 1, 0, 'h0100, 0, 0);
        step(); adv();
        step(); adv();
        rst_ni = 1'b1;

        // Write then read back through bank 1
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 'h0804, 4'hF, 32'hCAFEBABE);
        step();
        chk("t1_gnt", 32'(m_gnt_o), 32'b01);
        chk("t1_csb", 32'(s_csb_o), 32'b1101);
        chk("t1_web", 32'(s_web_o), 32'b1101);
        chk("t1_word", 32'(s_addr_o[WW +: WW]), 32'h001);
        adv();
        drive(0, 1, 0, 'h0804, 4'h0, 0);
        step();
        chk("t1_wresp", 32'(m_rvalid_o), 32'b01);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t1_rvalid", 32'(m_rvalid_o), 32'b01);
        chk("t1_rdata", m_rdata_o[31:0], 32'hCAFEBABE);
        adv();

        // Contention on bank 2
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 'h1000, 0, 0);
            drive(1, 1, 0, 'h1004, 0, 0);
            step();
            chk("t2_gnt", 32'(m_gnt_o), (i % 2 == 0) ? 32'b01 : 32'b10);
            adv();
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("t2_stall", 32'(stall_cnt_o), 6);
        adv();

        // Parallel banks
        drive(0, 1, 0, 'h0100, 0, 0);
        drive(1, 1, 0, 'h1100, 0, 0);
        step();
        chk("t3_gnt", 32'(m_gnt_o), 32'b11);
        chk("t3_csb", 32'(s_csb_o), 32'b1010);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("t3_stall", 32'(stall_cnt_o), 6);
        adv();

        // Out-of-range
        drive(1, 1, 0, 'h2000, 0, 0);
        step();
        chk("t4_gnt", 32'(m_gnt_o), 32'b10);
        chk("t4_csb", 32'(s_csb_o), 32'hF);
        adv();
        drive(1, 0, 0, 0, 0, 0);
        step();
        chk("t4_rvalid", 32'(m_rvalid_o), 32'b10);
        chk("t4_err", 32'(m_err_o), 32'b10);
        chk("t4_rdata", m_rdata_o[63:32], 0);
        adv();

        // Byte mask
        drive(0, 1, 1, 'h0808, 4'hF, 32'h11223344);
        step(); adv();
        drive(0, 1, 1, 'h0808, 4'b0100, 32'hAABBCCDD);
        step();
        chk("t5_wmask", 32'(s_wmask_o[7:4]), 32'b0100);
        adv();
        drive(0, 1, 0, 'h0808, 0, 0);
        step(); adv();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("t5_rdata", m_rdata_o[31:0], 32'h11BB3344);
        adv();

        // Top word of bank 0
        drive(0, 1, 0, 'h07FC, 0, 0);
        step();
        chk("bnd_word", 32'(s_addr_o[WW-1:0]), 32'h1FF);
        chk("bnd_csb", 32'(s_csb_o), 32'b1110);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        step(); adv();

        // Reset right after a grant
        drive(0, 1, 0, 'h1800, 0, 0);
        step(); adv();
        drive(0, 1, 0, 'h0000, 0, 0);
        step();
        chk("t6_pre_gnt", 32'(m_gnt_o), 32'b01);
        adv();
        rst_ni = 1'b0;
        model_reset();
        drive(0, 1, 0, 'h1800, 0, 0);
        drive(1, 1, 0, 'h1804, 0, 0);
        step();
        chk("t6_csb", 32'(s_csb_o), 32'hF);
        adv();
        rst_ni = 1'b1;
        step();
        chk("t6_rr", 32'(m_gnt_o), 32'b01);
        adv();
        drive(0, 0, 0, 0, 0, 0);
        step(); adv();
        drive(1, 0, 0, 0, 0, 0);
        step(); adv();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_ni = 1'b0;
                model_reset();
                step(); adv();
                step(); adv();
                rst_ni = 1'b1;
            end
            for (int c = 0; c < NCORE; c++) begin
                if (!(m_req_i[c] && !egnt[c])) begin
                    int ra;
                    if ($urandom_range(0, 7) == 0)
                        ra = int'($urandom_range(0, 'h3FFF));
                    else
                        ra = (int'($urandom_range(0, 3)) << 11)
                           | (int'($urandom_range(0, 7)) << 2);
                    drive(c, $urandom_range(0, 9) < 7, 1'($urandom),
                          ra, 4'($urandom), $urandom);
                end
            end
            step(); adv();
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        step(); adv();
        step(); adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
